mcycle_writeback: RTL and testbench

- Consumer end of the multi-cycle multiply/divide unit's result interface.
- Tracks which destination registers have an outstanding multi-cycle op (scoreboard) and gates new issues.
- Buffers completed results ({WA3, Result}, pushed by the unit's one-cycle push pulse) in a small FIFO.
- Drains the FIFO into the register file write port only in cycles when the main pipeline is not writing; stalls readers of pending registers.

---
 rtl/mcycle_writeback.sv | 168 ++++++++++++++++
 tb/tb_mcycle_writeback.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_writeback.sv
// ---------------------------------------------------------------------------
// mcycle_writeback
//
// Consumer end of the multi-cycle multiply/divide unit's result interface.
//  - Scoreboard: one Pending bit per architectural register. The bit is set
//    when an op targeting that register is issued. It is cleared when the
//    op's result is written to the register file.
//  - Issue gating: a new multi-cycle op is accepted only when the unit is
//    idle, its destination is not already pending, and the result FIFO has
//    room.
//  - Result FIFO: buffers {WA3, Result} pushed by the unit's one-cycle
//    MPushIn pulse.
//  - Drain: the FIFO head is written through the register file's
//    second-priority port, only in cycles when the main pipeline is not
//    writing.
//
// Parameters:
//   width  result data width
//   DEPTH  result FIFO entries (power of 2, >= 2)
//
// Ports:
//   CLK, Reset         clock, asynchronous active-high reset
//   IssueValid/IssueWA3/MCycleBusy -> IssueReady   issue handshake
//   MPushIn/MCycleWA3/MResult                      result push from unit
//   PipeRegWrite                                   main pipeline owns RF port
//   RA1/RA2 -> HazardStall                         decode read hazard check
//   MWrite/MWA3/MWD                                RF second write port
//   Pending                                        scoreboard bits
//   Overflow                                       sticky push-while-full flag
//
// Optional feature, macro MCYCLE_WB_FWD_EN:
//   Adds Fwd1/Fwd2. These flag that the register being drained this cycle
//   matches RA1/RA2. HazardStall then ignores that register, because decode
//   can take the value from MWD instead.
// ---------------------------------------------------------------------------
module mcycle_writeback #(
    parameter int width = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IssueValid,
    input  logic [3:0]       IssueWA3,
    input  logic             MCycleBusy,
    output logic             IssueReady,
    input  logic             MPushIn,
    input  logic [3:0]       MCycleWA3,
    input  logic [width-1:0] MResult,
    input  logic             PipeRegWrite,
    input  logic [3:0]       RA1,
    input  logic [3:0]       RA2,
    output logic             MWrite,
    output logic [3:0]       MWA3,
    output logic [width-1:0] MWD,
    output logic             HazardStall,
    output logic [15:0]      Pending,
    output logic             Overflow
`ifdef MCYCLE_WB_FWD_EN
    ,
    output logic             Fwd1,
    output logic             Fwd2
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]       wa3;
        logic [width-1:0] data;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        pending_q, pending_d;
    logic               overflow_q, overflow_d;

    logic               full;
    logic               push_ok;
    entry_t             head_entry;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_entry = fifo_q[head_q];

    assign MWrite     = (count_q != '0) & ~PipeRegWrite;
    assign MWA3       = head_entry.wa3;
    assign MWD        = head_entry.data;
    assign IssueReady = IssueValid & ~MCycleBusy & ~pending_q[IssueWA3] & ~full;
    assign Pending    = pending_q;
    assign Overflow   = overflow_q;

    // A push while full is accepted when the head pops at the same edge.
    // The slot being freed is the slot being written.
    assign push_ok    = MPushIn & (~full | MWrite);

`ifdef MCYCLE_WB_FWD_EN
    assign Fwd1        = MWrite & (MWA3 == RA1);
    assign Fwd2        = MWrite & (MWA3 == RA2);
    assign HazardStall = (pending_q[RA1] & ~Fwd1) | (pending_q[RA2] & ~Fwd2);
`else
    assign HazardStall = pending_q[RA1] | pending_q[RA2];
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred;
        // later blocking assignments override earlier ones, which encodes
        // "set beats clear" for the scoreboard below.
        pending_d  = pending_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (MPushIn & full & ~MWrite);

        if (MWrite) begin
            pending_d[MWA3] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (IssueReady) begin
            pending_d[IssueWA3] = 1'b1;
        end
        if (push_ok) begin
            tail_d = tail_q + PTR_W'(1);
        end

        case ({push_ok, MWrite})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            // NOTE: the FIFO storage is reset as well so that MWA3/MWD
            // read 0 out of reset. This is only cheap because the buffer
            // holds a couple of entries.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                fifo_q[tail_q] <= '{wa3: MCycleWA3, data: MResult};
            end
        end
    end

endmodule

// File: tb/tb_mcycle_writeback.sv
// ---------------------------------------------------------------------------
// tb_mcycle_writeback
//
// Self-checking bench for mcycle_writeback (width=32, DEPTH=2).
// The main part is a per-cycle vector table. Each row sets the inputs for
// one cycle and states the outputs expected just before the next rising
// edge. Hand-written sequences cover reset, including reset mid-operation,
// and, when MCYCLE_WB_FWD_EN is defined, the forwarding path.
// ---------------------------------------------------------------------------
module tb_mcycle_writeback;

    logic        CLK;
    logic        Reset;
    logic        IssueValid;
    logic [3:0]  IssueWA3;
    logic        MCycleBusy;
    logic        IssueReady;
    logic        MPushIn;
    logic [3:0]  MCycleWA3;
    logic [31:0] MResult;
    logic        PipeRegWrite;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic        MWrite;
    logic [3:0]  MWA3;
    logic [31:0] MWD;
    logic        HazardStall;
    logic [15:0] Pending;
    logic        Overflow;
`ifdef MCYCLE_WB_FWD_EN
    logic        Fwd1;
    logic        Fwd2;
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    mcycle_writeback #(.width(32), .DEPTH(2)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .IssueValid   (IssueValid),
        .IssueWA3     (IssueWA3),
        .MCycleBusy   (MCycleBusy),
        .IssueReady   (IssueReady),
        .MPushIn      (MPushIn),
        .MCycleWA3    (MCycleWA3),
        .MResult      (MResult),
        .PipeRegWrite (PipeRegWrite),
        .RA1          (RA1),
        .RA2          (RA2),
        .MWrite       (MWrite),
        .MWA3         (MWA3),
        .MWD          (MWD),
        .HazardStall  (HazardStall),
        .Pending      (Pending),
        .Overflow     (Overflow)
`ifdef MCYCLE_WB_FWD_EN
        ,
        .Fwd1         (Fwd1),
        .Fwd2         (Fwd2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [3:0]  iwa3;
        logic        busy;
        logic        push;
        logic [3:0]  pwa3;
        logic [31:0] res;
        logic        pipe;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        e_ir;
        logic        e_mw;
        logic [3:0]  e_mwa3;
        logic [31:0] e_mwd;
        logic        e_st;   // stall without forwarding
        logic        e_stf;  // stall with forwarding enabled
        logic [15:0] e_pend;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic iv, input logic [3:0] iwa3, input logic busy,
        input logic push, input logic [3:0] pwa3, input logic [31:0] res,
        input logic pipe, input logic [3:0] ra1, input logic [3:0] ra2,
        input logic e_ir, input logic e_mw, input logic [3:0] e_mwa3,
        input logic [31:0] e_mwd, input logic e_st, input logic e_stf,
        input logic [15:0] e_pend, input logic e_ovf);
        vec_t v;
        v.iv = iv; v.iwa3 = iwa3; v.busy = busy; v.push = push; v.pwa3 = pwa3;
        v.res = res; v.pipe = pipe; v.ra1 = ra1; v.ra2 = ra2;
        v.e_ir = e_ir; v.e_mw = e_mw; v.e_mwa3 = e_mwa3; v.e_mwd = e_mwd;
        v.e_st = e_st; v.e_stf = e_stf; v.e_pend = e_pend; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        IssueValid   = v.iv;
        IssueWA3     = v.iwa3;
        MCycleBusy   = v.busy;
        MPushIn      = v.push;
        MCycleWA3    = v.pwa3;
        MResult      = v.res;
        PipeRegWrite = v.pipe;
        RA1          = v.ra1;
        RA2          = v.ra2;
    endtask

    task automatic idle_inputs();
        IssueValid = 0; IssueWA3 = 0; MCycleBusy = 0; MPushIn = 0;
        MCycleWA3 = 0; MResult = 0; PipeRegWrite = 0; RA1 = 0; RA2 = 0;
    endtask

    initial begin
        //               iv iwa busy push pwa res          pipe ra1 ra2 | ir mw mwa mwd         st stf pend      ovf
        // basic path: issue r3, result 0x42 drained one cycle after push
        vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        vecs[1]  = mk(1, 3, 0, 0, 0, 32'h0,        0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 32'h0,        0, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[3]  = mk(0, 0, 0, 1, 3, 32'h42,       0, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0,   0, 1, 3, 32'h42,       1, 0, 16'h0008, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        // port conflict: pipeline holds the RF port for 3 cycles after the push
        vecs[6]  = mk(1, 3, 0, 0, 0, 32'h0,        0, 3, 0,   1, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        vecs[7]  = mk(0, 0, 0, 1, 3, 32'h42,       1, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,        1, 3, 0,   0, 0, 0, 32'h0,        1, 1, 16'h0008, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0,   0, 1, 3, 32'h42,       1, 0, 16'h0008, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        // issue gating: pending destination, busy unit
        vecs[13] = mk(1, 7, 0, 0, 0, 32'h0,        0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 16'h0000, 0);
        vecs[14] = mk(1, 7, 0, 0, 0, 32'h0,        0, 0, 7,   0, 0, 0, 32'h0,        1, 1, 16'h0080, 0);
        vecs[15] = mk(1, 2, 1, 0, 0, 32'h0,        0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 0);
        // FIFO fill, full gating, push+pop while full, overflow, ordered drain
        vecs[16] = mk(0, 0, 0, 1, 1, 32'hA,        1, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 0);
        vecs[17] = mk(0, 0, 0, 1, 2, 32'hB,        1, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 0);
        vecs[18] = mk(1, 9, 0, 0, 0, 32'h0,        1, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 0);
        vecs[19] = mk(0, 0, 0, 1, 7, 32'h77,       0, 0, 0,   0, 1, 1, 32'hA,        0, 0, 16'h0080, 0);
        vecs[20] = mk(0, 0, 0, 1, 4, 32'h44,       1, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 32'h0,        1, 0, 0,   0, 0, 0, 32'h0,        0, 0, 16'h0080, 1);
        vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 1, 2, 32'hB,        0, 0, 16'h0080, 1);
        vecs[23] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 7,   0, 1, 7, 32'h77,       1, 0, 16'h0080, 1);
        vecs[24] = mk(1, 9, 0, 0, 0, 32'h0,        0, 0, 7,   1, 0, 0, 32'h0,        0, 0, 16'h0000, 1);

        idle_inputs();
        Reset = 1'b1;

        // Reset state
        @(negedge CLK);
        #1;
        check("reset Pending",     32'(Pending),     32'h0);
        check("reset Overflow",    32'(Overflow),    32'h0);
        check("reset MWrite",      32'(MWrite),      32'h0);
        check("reset MWA3",        32'(MWA3),        32'h0);
        check("reset MWD",         MWD,              32'h0);
        check("reset HazardStall", 32'(HazardStall), 32'h0);
        @(negedge CLK);
        Reset = 1'b0;

        // Table-driven per-cycle vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            check($sformatf("r%0d IssueReady", i),  32'(IssueReady), 32'(vecs[i].e_ir));
            check($sformatf("r%0d MWrite", i),      32'(MWrite),     32'(vecs[i].e_mw));
            check($sformatf("r%0d HazardStall", i), 32'(HazardStall),
                  32'(FWD ? vecs[i].e_stf : vecs[i].e_st));
            check($sformatf("r%0d Pending", i),     32'(Pending),    32'(vecs[i].e_pend));
            check($sformatf("r%0d Overflow", i),    32'(Overflow),   32'(vecs[i].e_ovf));
            if (vecs[i].e_mw) begin
                check($sformatf("r%0d MWA3", i), 32'(MWA3), 32'(vecs[i].e_mwa3));
                check($sformatf("r%0d MWD", i),  MWD,       vecs[i].e_mwd);
            end
        end

        // Reset mid-operation: r9 pending from the table, r5 issued now,
        // one result buffered, Overflow sticky; reset discards all of it.
        @(negedge CLK);
        idle_inputs();
        IssueValid = 1; IssueWA3 = 5;
        #1;
        check("midrst issue r5", 32'(IssueReady), 32'h1);
        @(negedge CLK);
        idle_inputs();
        PipeRegWrite = 1; MPushIn = 1; MCycleWA3 = 6; MResult = 32'h66;
        #1;
        check("midrst Pending before", 32'(Pending), 32'h0220);
        @(negedge CLK);
        idle_inputs();
        RA1 = 5; RA2 = 9; PipeRegWrite = 1;
        #1;
        Reset = 1'b1;
        #1;
        check("midrst Pending",     32'(Pending),     32'h0);
        check("midrst Overflow",    32'(Overflow),    32'h0);
        check("midrst MWrite",      32'(MWrite),      32'h0);
        check("midrst HazardStall", 32'(HazardStall), 32'h0);
        check("midrst MWA3",        32'(MWA3),        32'h0);
        check("midrst MWD",         MWD,              32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        PipeRegWrite = 0;
        IssueValid = 1; IssueWA3 = 5;
        #1;
        check("postrst MWrite",     32'(MWrite),     32'h0);
        check("postrst IssueReady", 32'(IssueReady), 32'h1);

`ifdef MCYCLE_WB_FWD_EN
        // Forwarding: r4 drained while RA2=4 -> no stall, value on MWD
        @(negedge CLK);
        idle_inputs();
        IssueValid = 1; IssueWA3 = 4;
        #1;
        check("fwd issue r4", 32'(IssueReady), 32'h1);
        @(negedge CLK);
        idle_inputs();
        MPushIn = 1; MCycleWA3 = 4; MResult = 32'h77; RA2 = 4;
        #1;
        check("fwd stall before drain", 32'(HazardStall), 32'h1);
        @(negedge CLK);
        idle_inputs();
        RA2 = 4;
        #1;
        check("fwd MWrite",      32'(MWrite),      32'h1);
        check("fwd Fwd2",        32'(Fwd2),        32'h1);
        check("fwd Fwd1",        32'(Fwd1),        32'h0);
        check("fwd HazardStall", 32'(HazardStall), 32'h0);
        check("fwd MWD",         MWD,              32'h77);
`endif

        @(negedge CLK);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
